// File: rtl/serial_frame_unpacker_if.sv
// Stream-in / word-out bundle of the serial frame unpacker.
// The master side drives the serial stream and the read address; the slave side is the unpacker.
interface serial_frame_unpacker_if #(
  parameter int FCNT_W = 8
) ();
  logic              ena_in;
  logic              data_in;
  logic [3:0]        rd_addr;
  logic [3:0]        rd_data;
  logic              word_valid;
  logic [3:0]        word_addr;
  logic [3:0]        word_data;
  logic              frame_done;
  logic              frame_err;
  logic [FCNT_W-1:0] frame_cnt;
  logic              busy;

  modport master (
    output ena_in, data_in, rd_addr,
    input  rd_data, word_valid, word_addr, word_data,
    input  frame_done, frame_err, frame_cnt, busy
  );

  modport slave (
    input  ena_in, data_in, rd_addr,
    output rd_data, word_valid, word_addr, word_data,
    output frame_done, frame_err, frame_cnt, busy
  );
endinterface

// File: rtl/serial_frame_unpacker.sv
// Rebuilds {addr,data} bytes from an LSB-first serial stream and stores each data nibble
// in a 16x4 register file at its address nibble; flags word, frame and abort events.
module serial_frame_unpacker #(
  parameter int FRAME_WORDS = 16,
  parameter int FCNT_W      = 8
) (
  input logic                    clk,
  input logic                    rst,
  serial_frame_unpacker_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam logic [3:0] LAST_WORD = 4'(FRAME_WORDS - 1);

  state_t              state_r;
  state_t              next_state_s;
  logic [2:0]          bit_cnt_r;
  logic [3:0]          word_cnt_r;
  logic [6:0]          shift_r;
  logic [6:0]          shift_next_s;
  logic [3:0]          regfile_r [16];
  logic                word_valid_r;
  logic                frame_done_r;
  logic                frame_err_r;
  logic [3:0]          word_addr_r;
  logic [3:0]          word_data_r;
  logic [FCNT_W-1:0]   frame_cnt_r;
  logic                busy_r;
  logic                sample_s;
  logic                word_end_s;
  logic                frame_end_s;
  logic                abort_s;
  logic [3:0]          wr_addr_s;
  logic [3:0]          wr_data_s;

  // Next-state decode and per-edge event strobes
  always_comb begin
    next_state_s = state_r;
    sample_s     = 1'b0;
    abort_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.ena_in) begin
          // Entering edge already samples bit 0, so there is no dead cycle.
          next_state_s = RECV;
          sample_s     = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      RECV: begin
        if (bus.ena_in) begin
          next_state_s = RECV;
          sample_s     = 1'b1;
        end else begin
          next_state_s = IDLE;
          abort_s      = (bit_cnt_r != 3'd0) || (word_cnt_r != 4'd0);
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
    word_end_s  = sample_s && (bit_cnt_r == 3'd7);
    frame_end_s = word_end_s && (word_cnt_r == LAST_WORD);
  end

  // Shift-register update and completed-word fields (bit 7 comes straight from data_in)
  always_comb begin
    shift_next_s = shift_r;
    for (int i = 0; i < 7; i++) begin
      if (bit_cnt_r == 3'(i)) begin
        shift_next_s[i] = bus.data_in;
      end else begin
        shift_next_s[i] = shift_r[i];
      end
    end
    wr_addr_s = {bus.data_in, shift_r[6:4]};
    wr_data_s = shift_r[3:0];
  end

  // FSM, counters, shift register and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      bit_cnt_r    <= 3'd0;
      word_cnt_r   <= 4'd0;
      shift_r      <= 7'd0;
      word_valid_r <= 1'b0;
      frame_done_r <= 1'b0;
      frame_err_r  <= 1'b0;
      word_addr_r  <= 4'd0;
      word_data_r  <= 4'd0;
      frame_cnt_r  <= '0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      busy_r       <= (next_state_s == RECV);
      word_valid_r <= word_end_s;
      frame_done_r <= frame_end_s;
      frame_err_r  <= abort_s;
      if (sample_s) begin
        shift_r   <= shift_next_s;
        bit_cnt_r <= bit_cnt_r + 3'd1;
        if (word_end_s) begin
          word_addr_r <= wr_addr_s;
          word_data_r <= wr_data_s;
          if (frame_end_s) begin
            word_cnt_r  <= 4'd0;
            frame_cnt_r <= frame_cnt_r + FCNT_W'(1);
          end else begin
            word_cnt_r <= word_cnt_r + 4'd1;
          end
        end
      end else begin
        // Stream stopped: any partial word is discarded and the next start is word 0.
        bit_cnt_r  <= 3'd0;
        word_cnt_r <= 4'd0;
        shift_r    <= 7'd0;
      end
    end
  end

  // Register file: cleared on reset, written only by a completed word
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        regfile_r[i] <= 4'd0;
      end
    end else if (word_end_s) begin
      regfile_r[wr_addr_s] <= wr_data_s;
    end
  end

  assign bus.rd_data    = regfile_r[bus.rd_addr];
  assign bus.word_valid = word_valid_r;
  assign bus.frame_done = frame_done_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.word_addr  = word_addr_r;
  assign bus.word_data  = word_data_r;
  assign bus.frame_cnt  = frame_cnt_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_serial_frame_unpacker.sv
// Scoreboard bench for serial_frame_unpacker: a 16-word instance and a 4-word instance
// share one serial source; a select steers ena_in to one of them.
`timescale 1ns/100ps
module tb_serial_frame_unpacker;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  addr;
    logic [3:0]  data;
    logic        fdone;
    logic [7:0]  fcnt;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       ena_s;
  logic       din_s;
  logic       sel_s;
  logic [3:0] rd_addr_a;
  logic [3:0] rd_addr_b;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   wv_cnt_a = 0;
  int   widx [2];
  int   fw [2];
  logic [7:0] fcnt_m [2];
  exp_t qa [$];
  exp_t qb [$];
  int   errq [$];
  int   fdcyc_b [$];
  exp_t ea;
  exp_t eb;

  serial_frame_unpacker_if #(.FCNT_W(8)) ifa ();
  serial_frame_unpacker_if #(.FCNT_W(8)) ifb ();

  assign ifa.ena_in  = ena_s & ~sel_s;
  assign ifa.data_in = din_s;
  assign ifa.rd_addr = rd_addr_a;
  assign ifb.ena_in  = ena_s & sel_s;
  assign ifb.data_in = din_s;
  assign ifb.rd_addr = rd_addr_b;

  serial_frame_unpacker #(.FRAME_WORDS(16), .FCNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  serial_frame_unpacker #(.FRAME_WORDS(4),  .FCNT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected words/aborts whenever a DUT raises a pulse.
  always @(negedge clk) begin
    if (ifa.word_valid === 1'b1) begin
      wv_cnt_a++;
      if (qa.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_word_a: word_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        ea = qa.pop_front();
        check("word_cyc_a",   32'(cyc),            ea.cyc);
        check("word_addr_a",  32'(ifa.word_addr),  32'(ea.addr));
        check("word_data_a",  32'(ifa.word_data),  32'(ea.data));
        check("frame_done_a", 32'(ifa.frame_done), 32'(ea.fdone));
        check("frame_cnt_a",  32'(ifa.frame_cnt),  32'(ea.fcnt));
      end
    end else if (ifa.frame_done === 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL stray_frame_done_a: frame_done=1 expected 0 (cycle %0d)", cyc);
    end
    if (ifa.frame_err === 1'b1) begin
      if (errq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_err_a: frame_err=1 expected 0 (cycle %0d)", cyc);
      end else begin
        check("err_cyc_a", 32'(cyc), 32'(errq.pop_front()));
      end
    end
    if (ifb.word_valid === 1'b1) begin
      if (ifb.frame_done === 1'b1) fdcyc_b.push_back(cyc);
      if (qb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_word_b: word_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        eb = qb.pop_front();
        check("word_cyc_b",   32'(cyc),            eb.cyc);
        check("word_addr_b",  32'(ifb.word_addr),  32'(eb.addr));
        check("word_data_b",  32'(ifb.word_data),  32'(eb.data));
        check("frame_done_b", 32'(ifb.frame_done), 32'(eb.fdone));
        check("frame_cnt_b",  32'(ifb.frame_cnt),  32'(eb.fcnt));
      end
    end else if (ifb.frame_done === 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL stray_frame_done_b: frame_done=1 expected 0 (cycle %0d)", cyc);
    end
    if (ifb.frame_err === 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL unexpected_err_b: frame_err=1 expected 0 (cycle %0d)", cyc);
    end
  end

  task automatic send_bit(input logic b);
    ena_s = 1'b1;
    din_s = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [3:0] a, input logic [3:0] d);
    logic [7:0] w;
    exp_t       e;
    int         k;
    w = {a, d};
    k = sel_s ? 1 : 0;
    for (int i = 0; i < 8; i++) send_bit(w[i]);
    e.cyc   = 32'(cyc);
    e.addr  = a;
    e.data  = d;
    e.fdone = (widx[k] == fw[k] - 1);
    if (e.fdone) begin
      widx[k] = 0;
      fcnt_m[k] = fcnt_m[k] + 8'd1;
    end else begin
      widx[k] = widx[k] + 1;
    end
    e.fcnt = fcnt_m[k];
    if (k == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  task automatic idle(input int n);
    ena_s = 1'b0;
    din_s = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_word_valid"}, 32'(ifa.word_valid), 32'd0);
    check({tag, "_frame_done"}, 32'(ifa.frame_done), 32'd0);
    check({tag, "_frame_err"},  32'(ifa.frame_err),  32'd0);
    check({tag, "_word_addr"},  32'(ifa.word_addr),  32'd0);
    check({tag, "_word_data"},  32'(ifa.word_data),  32'd0);
    check({tag, "_frame_cnt"},  32'(ifa.frame_cnt),  32'd0);
    check({tag, "_busy"},       32'(ifa.busy),       32'd0);
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i);
      #0.1;
      check({tag, "_regfile"}, 32'(ifa.rd_data), 32'd0);
    end
  endtask

  task automatic model_reset();
    widx[0] = 0; widx[1] = 0;
    fcnt_m[0] = 8'd0; fcnt_m[1] = 8'd0;
  endtask

  initial begin
    fw[0] = 16; fw[1] = 4;
    model_reset();
    rst = 1'b1; ena_s = 1'b0; din_s = 1'b0; sel_s = 1'b0;
    rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_a("reset");
    rst = 1'b0;

    // One frame {i, 15-i}, then a second frame {i, i} back-to-back.
    for (int i = 0; i < 16; i++) send_word(4'(i), 4'(15 - i));
    check("busy_streaming", 32'(ifa.busy), 32'd1);
    check("f1_frame_cnt", 32'(ifa.frame_cnt), 32'd1);
    rd_addr_a = 4'd3; #0.1;
    check("f1_rd3", 32'(ifa.rd_data), 32'd12);
    for (int i = 0; i < 16; i++) send_word(4'(i), 4'(i));
    idle(1);
    check("f2_frame_cnt", 32'(ifa.frame_cnt), 32'd2);
    check("f2_wv_count", 32'(wv_cnt_a), 32'd32);
    check("f2_busy_idle", 32'(ifa.busy), 32'd0);
    rd_addr_a = 4'd3; #0.1;
    check("f2_rd3", 32'(ifa.rd_data), 32'd3);
    idle(2);

    // Abort after 37 bits: 4 full words plus 5 bits of word 4.
    for (int i = 0; i < 4; i++) send_word(4'(i), 4'(i + 8));
    begin
      logic [7:0] w4;
      w4 = 8'h4E;
      for (int i = 0; i < 5; i++) send_bit(w4[i]);
    end
    ena_s = 1'b0;
    @(posedge clk); #1;
    errq.push_back(cyc);
    widx[0] = 0;
    check("err_busy", 32'(ifa.busy), 32'd0);
    check("err_frame_cnt", 32'(ifa.frame_cnt), 32'd2);
    for (int i = 0; i < 5; i++) begin
      rd_addr_a = 4'(i); #0.1;
      check("err_regfile", 32'(ifa.rd_data), (i < 4) ? 32'(i + 8) : 32'd4);
    end
    idle(2);

    // Fresh frame with words 2 and 9 both targeting addr 5.
    for (int i = 0; i < 16; i++) begin
      if (i == 2)      send_word(4'd5, 4'hA);
      else if (i == 9) send_word(4'd5, 4'h6);
      else             send_word(4'(i), 4'(i));
    end
    idle(1);
    check("dup_frame_cnt", 32'(ifa.frame_cnt), 32'd3);
    rd_addr_a = 4'd5; #0.1;
    check("dup_rd5", 32'(ifa.rd_data), 32'd6);
    idle(1);

    // Reset asserted for one edge after 70 bits, stream kept enabled.
    for (int i = 0; i < 8; i++) send_word(4'(i), 4'(15 - i));
    begin
      logic [7:0] w8;
      w8 = 8'h87;
      for (int i = 0; i < 6; i++) send_bit(w8[i]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_zero_a("midrst");
    for (int i = 0; i < 16; i++) send_word(4'(i), 4'(i + 1));
    idle(1);
    check("post_rst_frame_cnt", 32'(ifa.frame_cnt), 32'd1);
    rd_addr_a = 4'd7; #0.1;
    check("post_rst_rd7", 32'(ifa.rd_data), 32'd8);
    idle(1);

    // Four-word frames on the second instance.
    sel_s = 1'b1;
    for (int i = 0; i < 4; i++) send_word(4'(i), 4'(3 - i));
    for (int i = 0; i < 4; i++) send_word(4'(i + 8), 4'(i));
    idle(1);
    check("b_frame_cnt", 32'(ifb.frame_cnt), 32'd2);
    rd_addr_b = 4'd9; #0.1;
    check("b_rd9", 32'(ifb.rd_data), 32'd1);
    if (fdcyc_b.size() == 2) begin
      check("b_frame_spacing", 32'(fdcyc_b[1] - fdcyc_b[0]), 32'd32);
    end else begin
      check("b_frame_done_count", 32'(fdcyc_b.size()), 32'd2);
    end
    idle(3);

    check("leftover_words_a", 32'(qa.size()), 32'd0);
    check("leftover_words_b", 32'(qb.size()), 32'd0);
    check("leftover_errs_a", 32'(errq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
